// File: rtl/kairo_mif_arb.sv
// kairo_mif_arb: I/D port memory interface; IMEM shared round-robin between I and D, DMEM owned by D.
// Optional define KAIRO_MIF_ARB_EXCPT_EN raises I/D_MEM_EXCPT on unmapped accesses.
module kairo_mif_arb #(
    parameter  int unsigned AW          = 32,
    parameter  int unsigned DW          = 32,
    parameter  int unsigned RD_LAT      = 1,
    parameter  logic [3:0]  IMEM_REGION = 4'h0,
    parameter  logic [3:0]  DMEM_REGION = 4'h1,
    localparam int unsigned SW          = DW / 8
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          I_MEM_VALID,
    input  logic [AW-1:0] I_MEM_ADDR,
    input  logic [DW-1:0] I_MEM_WDATA,
    input  logic [SW-1:0] I_MEM_WSTB,
    output logic          I_MEM_READY,
    output logic [DW-1:0] I_MEM_RDATA,
    output logic          I_MEM_EXCPT,
    input  logic          D_MEM_VALID,
    input  logic [AW-1:0] D_MEM_ADDR,
    input  logic [DW-1:0] D_MEM_WDATA,
    input  logic [SW-1:0] D_MEM_WSTB,
    output logic          D_MEM_READY,
    output logic [DW-1:0] D_MEM_RDATA,
    output logic          D_MEM_EXCPT,
    output logic [AW-1:0] IMEM_ADR,
    output logic          IMEM_RE,
    output logic [SW-1:0] IMEM_WEB,
    output logic [DW-1:0] IMEM_WDIN,
    input  logic [DW-1:0] IMEM_RDOUT,
    output logic [AW-1:0] DMEM_ADR,
    output logic          DMEM_RE,
    output logic [SW-1:0] DMEM_WEB,
    output logic [DW-1:0] DMEM_WDIN,
    input  logic [DW-1:0] DMEM_RDOUT
);

    localparam int unsigned   CW     = 3;
    localparam logic [CW-1:0] LAT    = CW'(RD_LAT);
    localparam logic [CW-1:0] CNT_1  = CW'(1);
    localparam logic          PORT_I = 1'b0;
    localparam logic          PORT_D = 1'b1;

    typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_RESP} state_t;
    typedef enum logic [1:0] {TGT_NONE, TGT_IMEM, TGT_DMEM} tgt_t;

    state_t          i_state_q, i_state_d, d_state_q, d_state_d;
    logic [CW-1:0]   i_cnt_q, i_cnt_d, d_cnt_q, d_cnt_d;
    tgt_t            i_tgt_q, i_tgt_d, d_tgt_q, d_tgt_d;
    logic            i_wr_q, i_wr_d, d_wr_q, d_wr_d;
    logic            i_ready_q, i_ready_d, d_ready_q, d_ready_d;
    logic [DW-1:0]   i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
    logic            last_q, last_d;

    logic            i_hit_imem, d_hit_imem, d_hit_dmem;
    logic            i_req_imem, d_req_imem, conflict;
    logic            i_gnt_imem, d_gnt_imem, d_gnt_dmem;
    logic            i_unm_issue, d_unm_issue, i_issue, d_issue;
    logic            i_idle_req, d_idle_req;

    // Read data comes only from the memory that owned the access; writes and unmapped return 0.
    function automatic logic [DW-1:0] rd_sel(input tgt_t tgt, input logic wr,
                                             input logic [DW-1:0] imem,
                                             input logic [DW-1:0] dmem);
        logic [DW-1:0] r;
        r = '0;
        if (!wr) begin
            if (tgt == TGT_IMEM)      r = imem;
            else if (tgt == TGT_DMEM) r = dmem;
        end
        return r;
    endfunction

    assign i_hit_imem = (I_MEM_ADDR[AW-1:AW-4] == IMEM_REGION);
    assign d_hit_imem = (D_MEM_ADDR[AW-1:AW-4] == IMEM_REGION);
    assign d_hit_dmem = (D_MEM_ADDR[AW-1:AW-4] == DMEM_REGION) && !d_hit_imem;

    // Requests are only recognised while out of reset so the SRAM pins stay quiet during reset.
    assign i_idle_req = RST_N && (i_state_q == ST_IDLE) && I_MEM_VALID;
    assign d_idle_req = RST_N && (d_state_q == ST_IDLE) && D_MEM_VALID;

    assign i_req_imem = i_idle_req && i_hit_imem;
    assign d_req_imem = d_idle_req && d_hit_imem;
    assign conflict   = i_req_imem && d_req_imem;

    // On conflict the port that did not win last time is granted; the loser retries next cycle.
    assign i_gnt_imem = i_req_imem && !(conflict && (last_q == PORT_I));
    assign d_gnt_imem = d_req_imem && !(conflict && (last_q == PORT_D));
    assign d_gnt_dmem = d_idle_req && d_hit_dmem;
    assign last_d     = conflict ? ~last_q : last_q;

    assign i_unm_issue = i_idle_req && !i_hit_imem;
    assign d_unm_issue = d_idle_req && !d_hit_imem && !d_hit_dmem;
    assign i_issue     = i_gnt_imem || i_unm_issue;
    assign d_issue     = d_gnt_imem || d_gnt_dmem || d_unm_issue;

    // I port next-state
    always_comb begin
        i_state_d = i_state_q;
        i_cnt_d   = i_cnt_q;
        i_tgt_d   = i_tgt_q;
        i_wr_d    = i_wr_q;
        i_ready_d = 1'b0;
        i_rdata_d = i_rdata_q;
        case (i_state_q)
            ST_IDLE: begin
                if (i_issue) begin
                    i_state_d = ST_BUSY;
                    i_cnt_d   = LAT;
                    i_tgt_d   = i_hit_imem ? TGT_IMEM : TGT_NONE;
                    i_wr_d    = |I_MEM_WSTB;
                end
            end
            ST_BUSY: begin
                if (i_cnt_q == CNT_1) begin
                    i_state_d = ST_RESP;
                    i_ready_d = 1'b1;
                    i_rdata_d = rd_sel(i_tgt_q, i_wr_q, IMEM_RDOUT, DMEM_RDOUT);
                end else begin
                    i_cnt_d = i_cnt_q - CNT_1;
                end
            end
            ST_RESP: i_state_d = ST_IDLE;
            default: i_state_d = ST_IDLE;
        endcase
    end

    // D port next-state
    always_comb begin
        d_state_d = d_state_q;
        d_cnt_d   = d_cnt_q;
        d_tgt_d   = d_tgt_q;
        d_wr_d    = d_wr_q;
        d_ready_d = 1'b0;
        d_rdata_d = d_rdata_q;
        case (d_state_q)
            ST_IDLE: begin
                if (d_issue) begin
                    d_state_d = ST_BUSY;
                    d_cnt_d   = LAT;
                    d_tgt_d   = d_hit_imem ? TGT_IMEM : (d_hit_dmem ? TGT_DMEM : TGT_NONE);
                    d_wr_d    = |D_MEM_WSTB;
                end
            end
            ST_BUSY: begin
                if (d_cnt_q == CNT_1) begin
                    d_state_d = ST_RESP;
                    d_ready_d = 1'b1;
                    d_rdata_d = rd_sel(d_tgt_q, d_wr_q, IMEM_RDOUT, DMEM_RDOUT);
                end else begin
                    d_cnt_d = d_cnt_q - CNT_1;
                end
            end
            ST_RESP: d_state_d = ST_IDLE;
            default: d_state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            i_state_q <= ST_IDLE;
            i_cnt_q   <= '0;
            i_tgt_q   <= TGT_NONE;
            i_wr_q    <= 1'b0;
            i_ready_q <= 1'b0;
            i_rdata_q <= '0;
            d_state_q <= ST_IDLE;
            d_cnt_q   <= '0;
            d_tgt_q   <= TGT_NONE;
            d_wr_q    <= 1'b0;
            d_ready_q <= 1'b0;
            d_rdata_q <= '0;
            last_q    <= PORT_I;
        end else begin
            i_state_q <= i_state_d;
            i_cnt_q   <= i_cnt_d;
            i_tgt_q   <= i_tgt_d;
            i_wr_q    <= i_wr_d;
            i_ready_q <= i_ready_d;
            i_rdata_q <= i_rdata_d;
            d_state_q <= d_state_d;
            d_cnt_q   <= d_cnt_d;
            d_tgt_q   <= d_tgt_d;
            d_wr_q    <= d_wr_d;
            d_ready_q <= d_ready_d;
            d_rdata_q <= d_rdata_d;
            last_q    <= last_d;
        end
    end

`ifdef KAIRO_MIF_ARB_EXCPT_EN
    logic i_excpt_q, d_excpt_q;

    // Exception flag pulses alongside READY for accesses that were decoded as unmapped.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            i_excpt_q <= 1'b0;
            d_excpt_q <= 1'b0;
        end else begin
            i_excpt_q <= (i_state_q == ST_BUSY) && (i_cnt_q == CNT_1) && (i_tgt_q == TGT_NONE);
            d_excpt_q <= (d_state_q == ST_BUSY) && (d_cnt_q == CNT_1) && (d_tgt_q == TGT_NONE);
        end
    end

    assign I_MEM_EXCPT = i_excpt_q;
    assign D_MEM_EXCPT = d_excpt_q;
`else
    assign I_MEM_EXCPT = 1'b0;
    assign D_MEM_EXCPT = 1'b0;
`endif

    // IMEM pins: driven only in the grant cycle of whichever port owns IMEM this cycle.
    always_comb begin
        IMEM_ADR  = '0;
        IMEM_RE   = 1'b0;
        IMEM_WEB  = '0;
        IMEM_WDIN = '0;
        if (i_gnt_imem) begin
            IMEM_ADR  = I_MEM_ADDR;
            IMEM_RE   = (I_MEM_WSTB == '0);
            IMEM_WEB  = I_MEM_WSTB;
            IMEM_WDIN = I_MEM_WDATA;
        end else if (d_gnt_imem) begin
            IMEM_ADR  = D_MEM_ADDR;
            IMEM_RE   = (D_MEM_WSTB == '0);
            IMEM_WEB  = D_MEM_WSTB;
            IMEM_WDIN = D_MEM_WDATA;
        end
    end

    // DMEM pins: D is the only possible owner.
    always_comb begin
        DMEM_ADR  = '0;
        DMEM_RE   = 1'b0;
        DMEM_WEB  = '0;
        DMEM_WDIN = '0;
        if (d_gnt_dmem) begin
            DMEM_ADR  = D_MEM_ADDR;
            DMEM_RE   = (D_MEM_WSTB == '0);
            DMEM_WEB  = D_MEM_WSTB;
            DMEM_WDIN = D_MEM_WDATA;
        end
    end

    assign I_MEM_READY = i_ready_q;
    assign I_MEM_RDATA = i_rdata_q;
    assign D_MEM_READY = d_ready_q;
    assign D_MEM_RDATA = d_rdata_q;

endmodule
